block_raster_reorder: RTL and testbench



---
 rtl/block_raster_reorder.sv | 251 +++++++++++++++++++++++++
 tb/tb_block_raster_reorder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_raster_reorder.sv
// block_raster_reorder
//   Converts decoded 8x8-block-order pixels into raster order using two
//   ping-pong strip banks (8 rows x IMG_W each). While one strip is read
//   out in raster order, the next strip is decoded into the other bank.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-high
//   in_valid_i     in_data_i holds a decoded pixel
//   in_data_i      decoded pixel (block order, row-major inside a block)
//   in_ready_o     block can accept a pixel this cycle
//   out_ready_i    downstream can accept the output pixel this cycle
//   out_valid_o    out_data_o/out_x_o/out_y_o/out_last_o are valid
//   out_data_o     raster-order pixel
//   out_x_o        column of the output pixel, 0..IMG_W-1
//   out_y_o        row of the output pixel, 0..IMG_H-1
//   out_last_o     output pixel is the final pixel of the frame
//   frame_done_o   pulses on the cycle the final frame pixel transfers out
module block_raster_reorder #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic [8:0] out_x_o,
  output logic [7:0] out_y_o,
  output logic       out_last_o,
  output logic       frame_done_o
);

  localparam int STRIP = 8 * IMG_W;
  localparam int AW    = $clog2(2 * STRIP);
  localparam int SW    = $clog2(STRIP);
  localparam int BPS   = IMG_W / 8;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_t;

  // Pixel plus the coordinate tags that travel with it to the output.
  typedef struct packed {
    logic [7:0] data;
    logic [8:0] x;
    logic [7:0] y;
    logic       last;
    logic       sl;    // final pixel of its strip
  } pix_t;

  logic [7:0]  r_mem [0:2*STRIP-1];
  bank_state_t r_bank     [2];
  bank_state_t w_bank_nxt [2];

  // Write side state
  logic [5:0]    r_p;
  logic [5:0]    r_blk;
  logic          r_wb;
  logic [SW-1:0] r_row_off;

  // Read side state
  logic          r_rb;
  logic [SW-1:0] r_rd_cnt;
  logic          r_rd_done;
  logic [8:0]    r_rx;
  logic [7:0]    r_ry;
  logic          r_rd_valid;
  logic [7:0]    r_rd_data;
  logic [8:0]    r_rd_x;
  logic [7:0]    r_rd_y;
  logic          r_rd_last;
  logic          r_rd_sl;

  // Output register and skid entry
  pix_t r_out;
  logic r_out_valid;
  pix_t r_skid;
  logic r_skid_valid;

  logic          w_in_ready;
  logic          w_in_fire;
  logic          w_strip_in_done;
  logic [AW-1:0] w_wr_addr;
  logic          w_out_fire;
  logic          w_drain;
  logic [1:0]    w_occ;
  logic          w_issue;
  logic [AW-1:0] w_rd_addr;
  logic          w_x_end;
  logic          w_strip_rd_end;
  logic          w_frame_end;
  pix_t          w_rd_pix;

  assign w_in_ready      = (r_bank[r_wb] == B_EMPTY) || (r_bank[r_wb] == B_FILLING);
  assign w_in_fire       = in_valid_i & w_in_ready;
  assign w_strip_in_done = w_in_fire && (r_p == 6'd63) && (r_blk == 6'(BPS - 1));
  // Bank base + running row offset + block column + pixel column; no multiplier.
  assign w_wr_addr = (r_wb ? AW'(STRIP) : {AW{1'b0}}) + AW'(r_row_off)
                   + AW'({r_blk, 3'b000}) + AW'(r_p[2:0]);

  assign w_out_fire = r_out_valid & out_ready_i;
  assign w_drain    = w_out_fire & r_out.sl;

  // Entries committed to the output stage: out register, skid, RAM read in flight.
  assign w_occ   = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_valid);
  assign w_issue = ((r_bank[r_rb] == B_FULL) || (r_bank[r_rb] == B_DRAINING)) && !r_rd_done
                && ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_out_fire));
  assign w_rd_addr = (r_rb ? AW'(STRIP) : {AW{1'b0}}) + AW'(r_rd_cnt);

  assign w_x_end        = (r_rx == 9'(IMG_W - 1));
  assign w_strip_rd_end = w_x_end && (r_ry[2:0] == 3'd7);
  assign w_frame_end    = w_x_end && (r_ry == 8'(IMG_H - 1));

  assign w_rd_pix = '{data: r_rd_data, x: r_rd_x, y: r_rd_y, last: r_rd_last, sl: r_rd_sl};

  // Bank FSM next state: writer moves EMPTY/FILLING banks, reader moves FULL/DRAINING banks.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_nxt[b] = r_bank[b];
      case (r_bank[b])
        B_EMPTY: begin
          if (w_in_fire && (r_wb == 1'(b))) w_bank_nxt[b] = B_FILLING;
          else                              w_bank_nxt[b] = B_EMPTY;
        end
        B_FILLING: begin
          if (w_strip_in_done && (r_wb == 1'(b))) w_bank_nxt[b] = B_FULL;
          else                                    w_bank_nxt[b] = B_FILLING;
        end
        B_FULL: begin
          if (r_rb == 1'(b)) w_bank_nxt[b] = B_DRAINING;
          else               w_bank_nxt[b] = B_FULL;
        end
        B_DRAINING: begin
          if (w_drain && (r_rb == 1'(b))) w_bank_nxt[b] = B_EMPTY;
          else                            w_bank_nxt[b] = B_DRAINING;
        end
        default: w_bank_nxt[b] = B_EMPTY;
      endcase
    end
  end

  // Bank FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank[0] <= B_EMPTY;
      r_bank[1] <= B_EMPTY;
    end else begin
      r_bank[0] <= w_bank_nxt[0];
      r_bank[1] <= w_bank_nxt[1];
    end
  end

  // Strip storage: write port from the decode side, registered read port.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) r_mem[w_wr_addr] <= in_data_i;
    if (w_issue)   r_rd_data <= r_mem[w_rd_addr];
  end

  // Write counters: pixel-in-block, block-in-strip, row offset, write bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p       <= 6'd0;
      r_blk     <= 6'd0;
      r_wb      <= 1'b0;
      r_row_off <= {SW{1'b0}};
    end else if (w_in_fire) begin
      r_p <= r_p + 6'd1;
      if (r_p[2:0] == 3'd7) begin
        if (r_p == 6'd63) begin
          r_row_off <= {SW{1'b0}};
          r_blk     <= (r_blk == 6'(BPS - 1)) ? 6'd0 : r_blk + 6'd1;
        end else begin
          r_row_off <= r_row_off + SW'(IMG_W);
        end
      end
      if (w_strip_in_done) r_wb <= ~r_wb;
    end
  end

  // Reader: raster address/coordinate generation and RAM-stage tags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rb       <= 1'b0;
      r_rd_cnt   <= {SW{1'b0}};
      r_rd_done  <= 1'b0;
      r_rx       <= 9'd0;
      r_ry       <= 8'd0;
      r_rd_valid <= 1'b0;
      r_rd_x     <= 9'd0;
      r_rd_y     <= 8'd0;
      r_rd_last  <= 1'b0;
      r_rd_sl    <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_rd_x    <= r_rx;
        r_rd_y    <= r_ry;
        r_rd_last <= w_frame_end;
        r_rd_sl   <= w_strip_rd_end;
        r_rd_cnt  <= w_strip_rd_end ? {SW{1'b0}} : r_rd_cnt + SW'(1);
        // Stop issuing once the whole strip is in flight; resume after it drains.
        r_rd_done <= w_strip_rd_end;
        r_rx      <= w_x_end ? 9'd0 : r_rx + 9'd1;
        if (w_x_end) r_ry <= w_frame_end ? 8'd0 : r_ry + 8'd1;
      end
      if (w_drain) begin
        r_rb      <= ~r_rb;
        r_rd_done <= 1'b0;
      end
    end
  end

  // Output register with one-entry skid: skid holds the RAM result when the output stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid       <= w_rd_pix;
        r_skid_valid <= r_rd_valid;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) r_out <= w_rd_pix;
      end
    end else if (r_rd_valid) begin
      r_skid       <= w_rd_pix;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready_o   = w_in_ready;
  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out.data;
  assign out_x_o      = r_out.x;
  assign out_y_o      = r_out.y;
  assign out_last_o   = r_out.last;
  assign frame_done_o = w_out_fire & r_out.last;

endmodule

// File: tb/tb_block_raster_reorder.sv
// Testbench for block_raster_reorder: drives block-order pixels, keeps an
// image scoreboard indexed by frame coordinate, and checks every output
// transfer plus directed corner cases (latency, backpressure, reset).
module tb_block_raster_reorder;

  localparam int W     = 320;
  localparam int H     = 24;
  localparam int BPS   = W / 8;
  localparam int SPF   = H / 8;
  localparam int FRAME = W * H;
  localparam int STRIP = 8 * W;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [8:0] out_x;
  logic [7:0] out_y;
  logic       out_last;
  logic       frame_done;

  block_raster_reorder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_x_o     (out_x),
    .out_y_o     (out_y),
    .out_last_o  (out_last),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] exp;
  } spot_t;

  spot_t strip_tab [6];
  spot_t frame_tab [6];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 1;

  logic [7:0] img [H][W];
  logic [7:0] cap [H][W];

  // driver position
  int d_p = 0, d_blk = 0, d_strip = 0, d_frame = 0;
  // monitor state
  int m_p = 0, m_blk = 0, m_strip = 0;
  int e_x = 0, e_y = 0;
  int acc_cnt = 0, out_cnt = 0, done_cnt = 0, last_cnt = 0;
  int first_valid_cyc = 0, last_acc_cyc = 0, last_xfer_cyc = 0;
  bit first_pending = 1'b1;
  bit prev_hold = 1'b0;
  logic [26:0] prev_vec;

  function automatic logic [7:0] pix_val(input int mode, input int x, input int y, input int fr);
    int v;
    case (mode)
      0:       v = (y / 8) * BPS + x / 8 + fr;
      1:       v = x + 3 * y;
      2:       v = (x * 7) ^ (y * 13) ^ (fr * 91) ^ 60;
      default: v = x ^ y ^ 165;
    endcase
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready pattern: 0 = held low, 1 = held high, 2 = random 50%
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_p = 0; m_blk = 0; m_strip = 0; e_x = 0; e_y = 0;
      acc_cnt = 0; out_cnt = 0; done_cnt = 0; last_cnt = 0;
      first_pending = 1'b1; prev_hold = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        img[m_strip * 8 + m_p / 8][m_blk * 8 + m_p % 8] = in_data;
        acc_cnt++;
        last_acc_cyc = cyc;
        m_p++;
        if (m_p == 64) begin
          m_p = 0; m_blk++;
          if (m_blk == BPS) begin
            m_blk = 0; m_strip++;
            if (m_strip == SPF) m_strip = 0;
          end
        end
      end
      if (prev_hold) begin
        n_checks++;
        if ({out_valid, out_data, out_x, out_y, out_last} !== prev_vec) begin
          n_errors++;
          $display("FAIL hold_stable: got %h, expected %h", {out_valid, out_data, out_x, out_y, out_last}, prev_vec);
        end
      end
      if (out_valid && first_pending) begin
        first_valid_cyc = cyc;
        first_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        logic [7:0] ed;
        logic       el;
        ed = img[e_y][e_x];
        el = (e_x == W - 1) && (e_y == H - 1);
        n_checks++;
        if (out_data !== ed || out_x !== 9'(e_x) || out_y !== 8'(e_y) || out_last !== el || frame_done !== el) begin
          n_errors++;
          $display("FAIL pix: got d=%h x=%0d y=%0d last=%b done=%b, expected d=%h x=%0d y=%0d last=%b done=%b",
                   out_data, out_x, out_y, out_last, frame_done, ed, e_x, e_y, el, el);
        end
        cap[e_y][e_x] = out_data;
        if (frame_done) done_cnt++;
        if (out_last) last_cnt++;
        out_cnt++;
        last_xfer_cyc = cyc;
        e_x++;
        if (e_x == W) begin
          e_x = 0; e_y++;
          if (e_y == H) e_y = 0;
        end
      end else begin
        chk("idle_done", 32'(frame_done), 32'd0);
      end
      prev_hold = out_valid && !out_ready;
      prev_vec  = {out_valid, out_data, out_x, out_y, out_last};
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({in_ready, out_valid, out_data, out_x, out_y, out_last, frame_done}),
        32'({1'b1, 1'b0, 8'd0, 9'd0, 8'd0, 1'b0, 1'b0}));
    rst = 1'b0;
    d_p = 0; d_blk = 0; d_strip = 0; d_frame = 0;
  endtask

  // Offer up to n pixels in block order; stops after n accepted or budget cycles.
  task automatic drive(input int n, input int budget, input int vprob, input int mode, output int got);
    int  t;
    bit  acc;
    got = 0;
    t = 0;
    while (got < n && t < budget) begin
      in_valid = ($urandom_range(99) < vprob);
      in_data  = pix_val(mode, d_blk * 8 + d_p % 8, d_strip * 8 + d_p / 8, d_frame);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        got++;
        d_p++;
        if (d_p == 64) begin
          d_p = 0; d_blk++;
          if (d_blk == BPS) begin
            d_blk = 0; d_strip++;
            if (d_strip == SPF) begin d_strip = 0; d_frame++; end
          end
        end
      end
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (out_cnt < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk(name, 32'(out_cnt), 32'(target));
  endtask

  initial begin
    int got;
    strip_tab[0] = '{0,   0, 8'd0};
    strip_tab[1] = '{319, 0, 8'd63};
    strip_tab[2] = '{0,   7, 8'd21};
    strip_tab[3] = '{319, 7, 8'd84};
    strip_tab[4] = '{100, 5, 8'd115};
    strip_tab[5] = '{255, 1, 8'd2};
    // second frame of the block-index pattern (value = block index + 1)
    frame_tab[0] = '{0,   0,  8'd1};
    frame_tab[1] = '{319, 0,  8'd40};
    frame_tab[2] = '{8,   8,  8'd42};
    frame_tab[3] = '{0,   16, 8'd81};
    frame_tab[4] = '{319, 23, 8'd120};
    frame_tab[5] = '{160, 12, 8'd61};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;

    // One strip, ready held high
    do_reset();
    rdy_mode = 1;
    drive(STRIP, 4000, 100, 1, got);
    chk("strip_accepted", 32'(got), 32'(STRIP));
    wait_out(STRIP, 4000, "strip_outputs");
    // accept edge follows the sampling negedge; valid appears 2 edges after it
    chk("strip_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd3);
    chk("strip_throughput", 32'(last_xfer_cyc - first_valid_cyc), 32'(STRIP - 1));
    chk("strip_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("strip_spot%0d", i), 32'(cap[strip_tab[i].y][strip_tab[i].x]), 32'(strip_tab[i].exp));

    // Two back-to-back frames, block-index pattern
    do_reset();
    drive(2 * FRAME, 20000, 100, 0, got);
    chk("frames_accepted", 32'(got), 32'(2 * FRAME));
    wait_out(2 * FRAME, 4000, "frames_outputs");
    chk("frames_done_cnt", 32'(done_cnt), 32'd2);
    chk("frames_last_cnt", 32'(last_cnt), 32'd2);
    for (int i = 0; i < 6; i++)
      chk($sformatf("frame_spot%0d", i), 32'(cap[frame_tab[i].y][frame_tab[i].x]), 32'(frame_tab[i].exp));

    // Output stalled across three strips of input
    do_reset();
    rdy_mode = 0;
    drive(FRAME, 5400, 100, 2, got);
    chk("bp_accepted", 32'(got), 32'(2 * STRIP));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", 32'({out_valid, out_data, out_x, out_y}), 32'({1'b1, pix_val(2, 0, 0, 0), 9'd0, 8'd0}));
    repeat (50) @(posedge clk);
    chk("bp_out_cnt", 32'(out_cnt), 32'd0);
    rdy_mode = 1;
    drive(FRAME - 2 * STRIP, 6000, 100, 2, got);
    chk("bp_rest_accepted", 32'(got), 32'(FRAME - 2 * STRIP));
    wait_out(FRAME, 6000, "bp_outputs");
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Random valid / ready over two frames
    do_reset();
    rdy_mode = 2;
    drive(2 * FRAME, 45000, 50, 2, got);
    chk("rand_accepted", 32'(got), 32'(2 * FRAME));
    wait_out(2 * FRAME, 8000, "rand_outputs");
    chk("rand_in_eq_out", 32'(acc_cnt), 32'(out_cnt));
    chk("rand_done_cnt", 32'(done_cnt), 32'd2);

    // Reset mid-stream, then a fresh frame
    do_reset();
    rdy_mode = 1;
    drive(1000, 1500, 100, 2, got);
    chk("mid_accepted", 32'(got), 32'd1000);
    do_reset();
    drive(FRAME, 9000, 100, 3, got);
    chk("fresh_accepted", 32'(got), 32'(FRAME));
    wait_out(FRAME, 4000, "fresh_outputs");
    chk("fresh_done_cnt", 32'(done_cnt), 32'd1);
    chk("fresh_first", 32'(cap[0][0]), 32'(pix_val(3, 0, 0, 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
